// File: rtl/counter_bcd_display_pkg.sv
//==============================================================================
// Module : counter_display_pkg
// Brief  : Shared FSM state type, 7-segment glyphs and parameter checks
//          for the BCD display path.
// Rev    : 1.0 - initial release
//==============================================================================
`default_nettype none

package counter_display_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Active-high segment patterns, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] C_SEG_0     = 7'b0111111;
  localparam logic [6:0] C_SEG_1     = 7'b0000110;
  localparam logic [6:0] C_SEG_2     = 7'b1011011;
  localparam logic [6:0] C_SEG_3     = 7'b1001111;
  localparam logic [6:0] C_SEG_4     = 7'b1100110;
  localparam logic [6:0] C_SEG_5     = 7'b1101101;
  localparam logic [6:0] C_SEG_6     = 7'b1111101;
  localparam logic [6:0] C_SEG_7     = 7'b0000111;
  localparam logic [6:0] C_SEG_8     = 7'b1111111;
  localparam logic [6:0] C_SEG_9     = 7'b1101111;
  localparam logic [6:0] C_SEG_BLANK = 7'b0000000;

  function automatic logic [6:0] seg7_glyph(input logic [3:0] nib);
    logic [6:0] g;
    case (nib)
      4'd0:    g = C_SEG_0;
      4'd1:    g = C_SEG_1;
      4'd2:    g = C_SEG_2;
      4'd3:    g = C_SEG_3;
      4'd4:    g = C_SEG_4;
      4'd5:    g = C_SEG_5;
      4'd6:    g = C_SEG_6;
      4'd7:    g = C_SEG_7;
      4'd8:    g = C_SEG_8;
      4'd9:    g = C_SEG_9;
      default: g = C_SEG_BLANK;
    endcase
    return g;
  endfunction

  // True when DIGITS decimal places can hold the largest WIDTH-bit value
  function automatic bit digits_ok(input int unsigned width, input int unsigned digits);
    longint unsigned p10;
    p10 = 64'd1;
    for (int unsigned i = 0; i < digits; i++) begin
      p10 = p10 * 64'd10;
    end
    return p10 > ((64'd1 << width) - 64'd1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/counter_bcd_display_if.sv
//==============================================================================
// Module : counter_bcd_display_if
// Brief  : Value input and BCD/display outputs of the display block.
// Rev    : 1.0 - initial release
//==============================================================================
`default_nettype none

interface counter_bcd_display_if #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
);
  logic [WIDTH-1:0]    value;
  logic [4*DIGITS-1:0] bcd;
  logic                bcd_valid;
  logic                busy;
  logic [6:0]          seg;
  logic [DIGITS-1:0]   digit_en;

  modport master (
    output value,
    input  bcd, bcd_valid, busy, seg, digit_en
  );

  modport slave (
    input  value,
    output bcd, bcd_valid, busy, seg, digit_en
  );
endinterface

`default_nettype wire

// File: rtl/counter_bcd_display_dabble.sv
//==============================================================================
// Module : bcd_double_dabble
// Brief  : Sequential binary-to-BCD converter, one shift/adjust per cycle.
// Rev    : 1.0 - initial release
//==============================================================================
`default_nettype none

module bcd_double_dabble
  import counter_display_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  wire logic                clock,
  input  wire logic                clear_n,
  input  wire logic                start,
  input  wire logic [WIDTH-1:0]    bin,
  output logic                     busy,
  output logic [4*DIGITS-1:0]      bcd,
  output logic                     done
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(WIDTH + 1);

  state_t            r_state;
  logic [WIDTH-1:0]  r_sr;
  logic [BCD_W-1:0]  r_acc;
  logic [BCD_W-1:0]  r_bcd;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_busy;
  logic              r_done;
  logic [BCD_W-1:0]  w_adj;

  always_comb begin
    w_adj = '0;
    for (int k = 0; k < DIGITS; k++) begin
      w_adj[4*k +: 4] = (r_acc[4*k +: 4] >= 4'd5) ? (r_acc[4*k +: 4] + 4'd3)
                                                  : r_acc[4*k +: 4];
    end
  end

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      r_state <= IDLE;
      r_sr    <= '0;
      r_acc   <= '0;
      r_bcd   <= '0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_sr    <= bin;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= SHIFT;
          end
        end
        SHIFT: begin
          {r_acc, r_sr} <= {w_adj, r_sr} << 1;
          r_cnt         <= r_cnt + 1'b1;
          if (r_cnt == CNT_W'(WIDTH - 1)) begin
            r_state <= DONE;
          end
        end
        DONE: begin
          r_bcd   <= r_acc;
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy = r_busy;
  assign bcd  = r_bcd;
  assign done = r_done;

endmodule

`default_nettype wire

// File: rtl/counter_bcd_display.sv
//==============================================================================
// Module : counter_bcd_display
// Brief  : Converts the seconds count to BCD and scans it onto a
//          multiplexed 7-segment display with leading-zero blanking.
// Rev    : 1.0 - initial release
//==============================================================================
`default_nettype none

module counter_bcd_display
  import counter_display_pkg::*;
#(
  parameter int WIDTH          = 8,
  parameter int DIGITS         = 3,
  parameter int REFRESH_DIV    = 1000,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input wire logic             clock,
  input wire logic             clear_n,
  counter_bcd_display_if.slave bus
);

  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int REF_W = $clog2(REFRESH_DIV);
  localparam logic [6:0]        C_SEG_RST = SEG_ACTIVE_LOW ? ~C_SEG_0 : C_SEG_0;
  localparam logic [DIGITS-1:0] C_EN_RST  = SEG_ACTIVE_LOW ? ~DIGITS'(1) : DIGITS'(1);

  if (!digits_ok(WIDTH, DIGITS)) begin : g_bad_digits
    $error("DIGITS cannot represent the full WIDTH range");
  end
  if (REFRESH_DIV < 2) begin : g_bad_refresh
    $error("REFRESH_DIV must be at least 2");
  end

  logic [WIDTH-1:0]    r_last_value;
  logic [REF_W-1:0]    r_refresh;
  logic [IDX_W-1:0]    r_idx;
  logic [6:0]          r_seg;
  logic [DIGITS-1:0]   r_digit_en;

  logic                w_busy;
  logic                w_done;
  logic                w_start;
  logic [4*DIGITS-1:0] w_bcd;
  logic                w_wrap;
  logic [IDX_W-1:0]    w_idx_nxt;
  logic [DIGITS-1:0]   w_blank;
  logic [6:0]          w_seg_hi;
  logic [DIGITS-1:0]   w_en_hi;

  // The converter is idle exactly when busy is low, so that gates sampling
  assign w_start = !w_busy && (bus.value != r_last_value);

  bcd_double_dabble #(
    .WIDTH  (WIDTH),
    .DIGITS (DIGITS)
  ) u_dabble (
    .clock   (clock),
    .clear_n (clear_n),
    .start   (w_start),
    .bin     (bus.value),
    .busy    (w_busy),
    .bcd     (w_bcd),
    .done    (w_done)
  );

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      r_last_value <= '0;
    end else if (w_start) begin
      r_last_value <= bus.value;
    end
  end

  assign w_wrap    = (r_refresh == REF_W'(REFRESH_DIV - 1));
  assign w_idx_nxt = !w_wrap ? r_idx :
                     (r_idx == IDX_W'(DIGITS - 1)) ? '0 : r_idx + 1'b1;

  // A digit blanks only when it and every more significant digit are zero
  always_comb begin
    w_blank = '0;
    for (int k = DIGITS - 1; k > 0; k--) begin
      w_blank[k] = (w_bcd[4*k +: 4] == 4'd0) && ((k == DIGITS - 1) || w_blank[(k + 1) % DIGITS]);
    end
  end

  always_comb begin
    w_seg_hi = C_SEG_BLANK;
    w_en_hi  = '0;
    for (int k = 0; k < DIGITS; k++) begin
      if (IDX_W'(k) == w_idx_nxt) begin
        w_seg_hi   = w_blank[k] ? C_SEG_BLANK : seg7_glyph(w_bcd[4*k +: 4]);
        w_en_hi[k] = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      r_refresh  <= '0;
      r_idx      <= '0;
      r_seg      <= C_SEG_RST;
      r_digit_en <= C_EN_RST;
    end else begin
      r_refresh <= w_wrap ? '0 : r_refresh + 1'b1;
      if (w_wrap) begin
        r_idx      <= w_idx_nxt;
        r_seg      <= SEG_ACTIVE_LOW ? ~w_seg_hi : w_seg_hi;
        r_digit_en <= SEG_ACTIVE_LOW ? ~w_en_hi : w_en_hi;
      end
    end
  end

  assign bus.bcd       = w_bcd;
  assign bus.bcd_valid = w_done;
  assign bus.busy      = w_busy;
  assign bus.seg       = r_seg;
  assign bus.digit_en  = r_digit_en;

endmodule

`default_nettype wire

// File: tb/tb_counter_bcd_display.sv
//==============================================================================
// Module : tb_counter_bcd_display
// Brief  : Directed self-checking bench for counter_bcd_display.
// Rev    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_counter_bcd_display;

  logic clock;
  logic clear_n;
  int   tests;
  int   fails;
  int   pulses;

  counter_bcd_display_if #(.WIDTH(8), .DIGITS(3)) bus ();

  counter_bcd_display #(
    .WIDTH          (8),
    .DIGITS         (3),
    .REFRESH_DIV    (4),
    .SEG_ACTIVE_LOW (1'b1)
  ) dut (
    .clock   (clock),
    .clear_n (clear_n),
    .bus     (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (bus.bcd_valid === 1'b1) pulses++;
  end

  function automatic logic [11:0] dec_ref(input int v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  task automatic convert(input logic [7:0] v, output logic ok);
    @(negedge clock);
    bus.value = v;
    ok = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clock); #1;
      if (bus.bcd_valid === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    int p0;
    clear_n   = 1'b0;
    bus.value = 8'd0;
    repeat (3) @(posedge clock);
    #1;
    tests++; if (bus.bcd !== 12'h000)      begin fails++; $display("FAIL reset_bcd: got %h exp 000", bus.bcd); end
    tests++; if (bus.bcd_valid !== 1'b0)   begin fails++; $display("FAIL reset_valid: got %b exp 0", bus.bcd_valid); end
    tests++; if (bus.busy !== 1'b0)        begin fails++; $display("FAIL reset_busy: got %b exp 0", bus.busy); end
    tests++; if (bus.digit_en !== 3'b110)  begin fails++; $display("FAIL reset_en: got %b exp 110", bus.digit_en); end
    tests++; if (bus.seg !== 7'b1000000)   begin fails++; $display("FAIL reset_seg: got %b exp 1000000", bus.seg); end
    @(negedge clock);
    clear_n = 1'b1;
    p0 = pulses;
    repeat (20) @(posedge clock);
    #1;
    tests++; if (pulses - p0 !== 0)        begin fails++; $display("FAIL reset_noconv: got %0d pulses exp 0", pulses - p0); end
    tests++; if (bus.busy !== 1'b0)        begin fails++; $display("FAIL reset_idle_busy: got %b exp 0", bus.busy); end
  endtask

  task automatic test_full_scale();
    int p0;
    @(negedge clock);
    p0 = pulses;
    bus.value = 8'd255;
    @(posedge clock); #1;
    tests++; if (bus.busy !== 1'b1) begin fails++; $display("FAIL fs_busy_T: got %b exp 1", bus.busy); end
    for (int e = 1; e <= 8; e++) begin
      @(posedge clock); #1;
      tests++; if (bus.busy !== 1'b1 || bus.bcd_valid !== 1'b0) begin
        fails++; $display("FAIL fs_busy_T+%0d: got busy=%b valid=%b exp 1/0", e, bus.busy, bus.bcd_valid);
      end
    end
    @(posedge clock); #1;
    tests++; if (bus.bcd !== 12'h255 || bus.bcd_valid !== 1'b1 || bus.busy !== 1'b0) begin
      fails++; $display("FAIL fs_done: got bcd=%h valid=%b busy=%b exp 255/1/0", bus.bcd, bus.bcd_valid, bus.busy);
    end
    @(posedge clock); #1;
    tests++; if (bus.bcd_valid !== 1'b0) begin fails++; $display("FAIL fs_pulse_clear: got %b exp 0", bus.bcd_valid); end
    @(negedge clock);
    tests++; if (pulses - p0 !== 1) begin fails++; $display("FAIL fs_pulses: got %0d exp 1", pulses - p0); end
  endtask

  task automatic test_scan();
    logic       ok;
    logic       synced;
    logic [2:0] prev;
    logic [2:0] exp_en  [3];
    logic [6:0] exp_seg [3];
    exp_en[0] = 3'b110; exp_seg[0] = 7'b1111000;
    exp_en[1] = 3'b101; exp_seg[1] = 7'b1111111;
    exp_en[2] = 3'b011; exp_seg[2] = 7'b1111111;
    convert(8'd7, ok);
    tests++; if (!ok || bus.bcd !== 12'h007) begin fails++; $display("FAIL scan_conv: got ok=%b bcd=%h exp 1/007", ok, bus.bcd); end
    synced = 1'b0;
    prev   = bus.digit_en;
    for (int i = 0; i < 20 && !synced; i++) begin
      @(posedge clock); #1;
      if (bus.digit_en === 3'b110 && prev !== 3'b110) synced = 1'b1;
      prev = bus.digit_en;
    end
    tests++; if (!synced) begin fails++; $display("FAIL scan_sync: got no ones slot exp slot within 20 clocks"); end
    for (int s = 0; s < 6; s++) begin
      for (int c = 0; c < 4; c++) begin
        tests++; if (bus.digit_en !== exp_en[s % 3] || bus.seg !== exp_seg[s % 3]) begin
          fails++; $display("FAIL scan_s%0d_c%0d: got en=%b seg=%b exp en=%b seg=%b",
                            s, c, bus.digit_en, bus.seg, exp_en[s % 3], exp_seg[s % 3]);
        end
        @(posedge clock); #1;
      end
    end
  endtask

  task automatic test_back_to_back();
    int   p0;
    logic exp_v;
    @(negedge clock);
    p0 = pulses;
    bus.value = 8'd100;
    @(posedge clock); #1;
    for (int e = 1; e <= 22; e++) begin
      @(posedge clock); #1;
      exp_v = (e == 9) || (e == 19);
      tests++; if (bus.bcd_valid !== exp_v) begin
        fails++; $display("FAIL b2b_valid_T+%0d: got %b exp %b", e, bus.bcd_valid, exp_v);
      end
      if (e == 2) bus.value = 8'd200;
      if (e == 9) begin
        tests++; if (bus.bcd !== 12'h100) begin fails++; $display("FAIL b2b_first: got %h exp 100", bus.bcd); end
      end
      if (e == 10) begin
        tests++; if (bus.busy !== 1'b1) begin fails++; $display("FAIL b2b_restart: got busy=%b exp 1", bus.busy); end
      end
      if (e == 19) begin
        tests++; if (bus.bcd !== 12'h200) begin fails++; $display("FAIL b2b_second: got %h exp 200", bus.bcd); end
      end
    end
    @(negedge clock);
    tests++; if (pulses - p0 !== 2) begin fails++; $display("FAIL b2b_pulses: got %0d exp 2", pulses - p0); end
  endtask

  task automatic test_reset_mid();
    int         p0;
    logic       ok;
    logic       seen;
    logic [2:0] prev;
    @(negedge clock);
    p0 = pulses;
    bus.value = 8'd99;
    @(posedge clock);
    repeat (4) @(posedge clock);
    #2;
    clear_n = 1'b0;
    #1;
    tests++; if (bus.busy !== 1'b0 || bus.bcd !== 12'h000 || bus.bcd_valid !== 1'b0) begin
      fails++; $display("FAIL rmid_async: got busy=%b bcd=%h valid=%b exp 0/000/0", bus.busy, bus.bcd, bus.bcd_valid);
    end
    tests++; if (bus.digit_en !== 3'b110 || bus.seg !== 7'b1000000) begin
      fails++; $display("FAIL rmid_disp: got en=%b seg=%b exp 110/1000000", bus.digit_en, bus.seg);
    end
    repeat (2) @(posedge clock);
    @(negedge clock);
    clear_n = 1'b1;
    tests++; if (pulses - p0 !== 0) begin fails++; $display("FAIL rmid_nopulse: got %0d exp 0", pulses - p0); end
    ok = 1'b0;
    for (int i = 0; i < 30 && !ok; i++) begin
      @(posedge clock); #1;
      if (bus.bcd_valid === 1'b1) ok = 1'b1;
    end
    tests++; if (!ok || bus.bcd !== 12'h099) begin fails++; $display("FAIL rmid_reconv: got ok=%b bcd=%h exp 1/099", ok, bus.bcd); end
    seen = 1'b0;
    prev = bus.digit_en;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(posedge clock); #1;
      if (bus.digit_en === 3'b101 && prev !== 3'b101) seen = 1'b1;
      prev = bus.digit_en;
    end
    tests++; if (!seen || bus.seg !== 7'b0010000) begin
      fails++; $display("FAIL rmid_tens: got seen=%b seg=%b exp 1/0010000", seen, bus.seg);
    end
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(posedge clock); #1;
      if (bus.digit_en === 3'b011 && prev !== 3'b011) seen = 1'b1;
      prev = bus.digit_en;
    end
    tests++; if (!seen || bus.seg !== 7'b1111111) begin
      fails++; $display("FAIL rmid_hundreds: got seen=%b seg=%b exp 1/1111111", seen, bus.seg);
    end
  endtask

  task automatic test_sweep();
    logic ok;
    for (int v = 0; v < 256; v++) begin
      convert(8'(v), ok);
      tests++; if (!ok || bus.bcd !== dec_ref(v)) begin
        fails++; $display("FAIL sweep_%0d: got ok=%b bcd=%h exp 1/%h", v, ok, bus.bcd, dec_ref(v));
      end
    end
  endtask

  initial begin
    tests     = 0;
    fails     = 0;
    pulses    = 0;
    clear_n   = 1'b0;
    bus.value = 8'd0;
    test_reset();
    test_full_scale();
    test_scan();
    test_back_to_back();
    test_reset_mid();
    test_sweep();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
